// File: rtl/mem_master_pkg.sv
// rtl/mem_master_pkg.sv - shared state encoding and default widths for mem_master
package mem_master_pkg;

    localparam int ADDR_W_DEF = 2;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
`ifdef MEM_MASTER_READBACK_EN
        ST_VERIFY,
`endif
        ST_RESP
    } state_t;

endpackage

// File: rtl/mem_master.sv
// rtl/mem_master.sv - single-request memory master FSM; MEM_MASTER_READBACK_EN adds store read-back check
module mem_master
    import mem_master_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
`ifdef MEM_MASTER_READBACK_EN
    logic              err_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef MEM_MASTER_READBACK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
`ifdef MEM_MASTER_READBACK_EN
                        err_q   <= 1'b0;
`endif
                    end
                end
`ifdef MEM_MASTER_READBACK_EN
                ST_VERIFY: begin
                    rdata_q <= mem_rdata;
                    err_q   <= (mem_rdata != wdata_q);
                end
`else
                // Without read-back the store response simply echoes the written data.
                ST_WRITE: rdata_q <= wdata_q;
`endif
                ST_READ:  rdata_q <= mem_rdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = req_write ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                mem_we = 1'b1;
`ifdef MEM_MASTER_READBACK_EN
                state_d = ST_VERIFY;
`else
                state_d = ST_RESP;
`endif
            end
            ST_READ: state_d = ST_RESP;
`ifdef MEM_MASTER_READBACK_EN
            ST_VERIFY: state_d = ST_RESP;
`endif
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
`ifdef MEM_MASTER_READBACK_EN
    assign rsp_err   = err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_master.sv
// tb/tb_mem_master.sv - directed self-checking bench for mem_master with a 4x8 memory responder
module tb_mem_master;

`ifdef MEM_MASTER_READBACK_EN
    localparam int STORE_LAT = 3;
`else
    localparam int STORE_LAT = 2;
`endif
    localparam int LOAD_LAT = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [1:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       mem_we;
    logic [1:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy;

    logic [7:0] mem [4];
    logic       force_zero;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    mem_master dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = force_zero ? 8'h00 : mem[mem_addr];

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic issue(input logic w, input logic [1:0] a, input logic [7:0] d);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        tick();
        req_valid = 1'b0;
    endtask

    // Called right after the accepting edge; lat counts edges from acceptance.
    task automatic wait_rsp(output int lat, output int we_n, output logic [7:0] d, output logic e);
        bit done;
        done = 0;
        lat  = 1;
        we_n = 0;
        d    = 8'h00;
        e    = 1'b0;
        while (!done) begin
            if (mem_we === 1'b1) we_n++;
            if (rsp_valid === 1'b1) begin
                d    = rsp_rdata;
                e    = rsp_err;
                done = 1;
            end else if (lat >= 10) begin
                checks++;
                errors++;
                $display("FAIL rsp_timeout: no rsp_valid after %0d cycles", lat);
                done = 1;
            end else begin
                tick();
                lat++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 2'd0;
        req_wdata = 8'h00; rsp_ready = 1'b0; force_zero = 1'b0;
        for (int i = 0; i < 4; i++) mem[i] = 8'h00;
        repeat (3) tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        checks++; if (rsp_rdata !== 8'h00) begin errors++; $display("FAIL reset_rsp_rdata: got %h expected 00", rsp_rdata); end
        checks++; if (mem_addr !== 2'd0) begin errors++; $display("FAIL reset_mem_addr: got %0d expected 0", mem_addr); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_store();
        int lat, we_n; logic [7:0] d; logic e;
        rsp_ready = 1'b1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL store_req_ready: got %b expected 1", req_ready); end
        issue(1'b1, 2'd2, 8'hA5);
        checks++; if (mem_addr !== 2'd2) begin errors++; $display("FAIL store_mem_addr: got %0d expected 2", mem_addr); end
        checks++; if (mem_wdata !== 8'hA5) begin errors++; $display("FAIL store_mem_wdata: got %h expected a5", mem_wdata); end
        wait_rsp(lat, we_n, d, e);
        checks++; if (lat !== STORE_LAT) begin errors++; $display("FAIL store_latency: got %0d expected %0d", lat, STORE_LAT); end
        checks++; if (we_n !== 1) begin errors++; $display("FAIL store_we_cycles: got %0d expected 1", we_n); end
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL store_rdata: got %h expected a5", d); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL store_err: got %b expected 0", e); end
        tick();
        checks++; if (mem[2] !== 8'hA5) begin errors++; $display("FAIL store_mem2: got %h expected a5", mem[2]); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL store_rsp_drop: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_load();
        int lat, we_n; logic [7:0] d; logic e;
        rsp_ready = 1'b1;
        issue(1'b1, 2'd1, 8'h3C);
        wait_rsp(lat, we_n, d, e);
        tick();
        issue(1'b0, 2'd1, 8'h00);
        wait_rsp(lat, we_n, d, e);
        checks++; if (d !== 8'h3C) begin errors++; $display("FAIL load_rdata: got %h expected 3c", d); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL load_err: got %b expected 0", e); end
        checks++; if (we_n !== 0) begin errors++; $display("FAIL load_we_cycles: got %0d expected 0", we_n); end
        checks++; if (lat !== LOAD_LAT) begin errors++; $display("FAIL load_latency: got %0d expected %0d", lat, LOAD_LAT); end
        tick();
    endtask

    task automatic test_backpressure();
        int lat, we_n; logic [7:0] d; logic e;
        mem[0] = 8'h11;
        mem[3] = 8'h33;
        rsp_ready = 1'b0;
        issue(1'b0, 2'd0, 8'h00);
        wait_rsp(lat, we_n, d, e);
        checks++; if (d !== 8'h11) begin errors++; $display("FAIL bp_rdata: got %h expected 11", d); end
        for (int i = 0; i < 5; i++) begin
            req_valid = (i == 1);
            req_write = 1'b1;
            req_addr  = 2'd3;
            req_wdata = 8'h77;
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_hold[%0d]: got %b expected 1", i, rsp_valid); end
            checks++; if (rsp_rdata !== 8'h11) begin errors++; $display("FAIL bp_rdata_hold[%0d]: got %h expected 11", i, rsp_rdata); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready[%0d]: got %b expected 0", i, req_ready); end
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_return_idle: got %b expected 1", req_ready); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_ignored_req_busy: got %b expected 0", busy); end
        checks++; if (mem[3] !== 8'h33) begin errors++; $display("FAIL bp_mem3: got %h expected 33", mem[3]); end
    endtask

    task automatic test_reset_in_write();
        rsp_ready = 1'b1;
        mem[3] = 8'h00;
        issue(1'b1, 2'd3, 8'hFF);
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rw_in_write: got %b expected 1", mem_we); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rw_mem_we: got %b expected 0", mem_we); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rw_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_rdata !== 8'h00) begin errors++; $display("FAIL rw_rsp_rdata: got %h expected 00", rsp_rdata); end
        checks++; if (mem_addr !== 2'd0) begin errors++; $display("FAIL rw_mem_addr: got %0d expected 0", mem_addr); end
        checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL rw_mem_wdata: got %h expected 00", mem_wdata); end
        checks++; if (mem[3] !== 8'hFF) begin errors++; $display("FAIL rw_mem3: got %h expected ff", mem[3]); end
        tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rw_req_ready: got %b expected 1", req_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rw_no_rsp[%0d]: got %b expected 0", i, rsp_valid); end
        end
    endtask

`ifdef MEM_MASTER_READBACK_EN
    task automatic test_readback();
        int lat, we_n; logic [7:0] d; logic e;
        rsp_ready  = 1'b1;
        force_zero = 1'b1;
        issue(1'b1, 2'd0, 8'h81);
        wait_rsp(lat, we_n, d, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL rb_err: got %b expected 1", e); end
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rb_rdata: got %h expected 00", d); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL rb_latency: got %0d expected 3", lat); end
        tick();
        force_zero = 1'b0;
    endtask
`endif

    task automatic test_back_to_back();
        int lat, we_n; logic [7:0] d; logic e;
        int acc, prev;
        logic [7:0] exp_d;
        mem[0] = 8'hD0; mem[1] = 8'hD1; mem[2] = 8'hD2; mem[3] = 8'hD3;
        rsp_ready = 1'b1;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_write = 1'b0;
            req_addr  = 2'(i);
            exp_d     = 8'hD0 + 8'(i);
            checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, req_ready); end
            tick();
            acc = cyc;
            wait_rsp(lat, we_n, d, e);
            checks++; if (d !== exp_d) begin errors++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", i, d, exp_d); end
            if (i > 0) begin
                checks++; if (acc - prev !== 3) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d expected 3", i, acc - prev); end
            end
            prev = acc;
            tick();
        end
        req_valid = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_store();
        test_load();
        test_backpressure();
        test_reset_in_write();
`ifdef MEM_MASTER_READBACK_EN
        test_readback();
`endif
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
